c1908_resp_misr: RTL and testbench
==================================

Name: c1908_resp_misr

Overview:
- Downstream response-capture stage for the registered c1908 benchmark wrapper (clocked input/output flip-flops).
- Compacts the 25 registered primary outputs (Q_PNN2753 … Q_PNN2899, packed LSB-first in that port order) into a 25-bit multiple-input signature register (MISR) over a programmed number of clock cycles.
- Compares the final signature against an expected value and reports pass/fail.
- Replaces cycle-by-cycle output dumping in benchmark runs with one self-checking signature.

Parameters:
- WIDTH, 25, response and signature width (c1908 output count).
- CNT_W, 16, width of the cycle counter and of num_cycles.
- POLY, 25'h0000008, feedback tap mask (bit i set = sig[WIDTH-1] XORed into bit i); default implements x^25+x^3+1.
- SEED, 25'h0000000, signature value loaded on start.
- LAT, 2, number of valid samples discarded after start (input-FF plus output-FF pipeline fill).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, begin capture; honoured only in IDLE or DONE.
- abort, input, 1, return to IDLE from any non-IDLE state.
- num_cycles, input, CNT_W, number of samples to compact; sampled on accepted start.
- resp_in, input, WIDTH, registered c1908 outputs.
- resp_valid, input, 1, resp_in holds a meaningful sample this cycle.
- expected_sig, input, WIDTH, golden signature; sampled on the DONE-entry edge.
- busy, output, 1, high in SKIP and RUN.
- done, output, 1, high while in DONE.
- pass, output, 1, signature==expected_sig; valid only while done=1.
- signature, output, WIDTH, current MISR contents.
- cycle_count, output, CNT_W, samples compacted since start.

Behaviour:
- Reset is synchronous and active-high. On reset: state=IDLE, busy=0, done=0, pass=0, signature=SEED, cycle_count=0, skip counter=0, latched count=0. Reset overrides all other inputs, including mid-run.
- States: IDLE, SKIP, RUN, DONE.
- IDLE/DONE with start=1:
  - Latch num_cycles; signature<=SEED; cycle_count<=0; done<=0; pass<=0.
  - Next state is SKIP if LAT>0, else RUN. If latched num_cycles==0, next state is DONE regardless of LAT.
- SKIP: each resp_valid=1 increments the skip counter. On the LAT-th valid sample go to RUN; that sample is not compacted.
- RUN, on each resp_valid=1:
  - sig'[0] = sig[W-1] ^ d[0].
  - sig'[i] = sig[i-1] ^ d[i] ^ (POLY[i] & sig[W-1]) for i≥1.
  - cycle_count++.
  - When cycle_count+1==latched count, the same edge performs the last update and state<=DONE.
  - resp_valid=0 holds signature and count (stall).
- DONE entry: pass <= (final signature == expected_sig), computed from the updated signature; done=1 on the cycle after the last sample. State, signature and pass hold until start, abort or reset.
- abort=1 in SKIP/RUN/DONE: state<=IDLE, busy=0, done=0, pass=0; signature and cycle_count hold (debug visibility). abort takes priority over start and resp_valid on the same edge.
- start in SKIP/RUN is ignored; no restart mid-run.
- cycle_count never wraps: the maximum run is 2^CNT_W-1 samples.
- Outputs are registered; no combinational input→output paths.

Test Plan:
- Reset mid-RUN (after 3 samples) → next cycle: IDLE, signature=0, cycle_count=0, busy=0, done=0.
- LAT=2, start with num_cycles=1, resp_valid=1, resp_in=25'h0000001 for 3 cycles → first two discarded; signature=25'h0000001, cycle_count=1, done=1 on the 4th edge after start; pass=1 when expected_sig=25'h0000001.
- num_cycles=2, resp_in=25'h0000001 both RUN samples → signature=25'h0000003; with expected_sig=25'h0000002 → pass=0, done=1.
- Feedback check: seed run to signature=25'h1000000, then one sample resp_in=0 → signature=25'h0000009 (bit 0 plus tap bit 3).
- Stall: resp_valid low for 5 cycles mid-RUN → signature and cycle_count unchanged; the final result equals the unstalled run.
- num_cycles=0 → DONE on the next edge, signature=SEED; start asserted during RUN → ignored; abort and start on the same edge → IDLE.

Source files
------------

// File: rtl/c1908_resp_misr.sv
// c1908_resp_misr: response-capture MISR for the registered c1908 wrapper.
// Compacts the registered primary outputs into a signature over a
// programmed number of valid samples. The first LAT valid samples after
// start are discarded while the input/output flops fill. The final
// signature is then compared against a golden value.
//
// Handshake: resp_valid is a one-way qualifier with no ready signal.
// On every rising edge where resp_valid=1, resp_in is consumed:
// discarded in SKIP, compacted in RUN, and ignored in IDLE/DONE.
// With resp_valid=0, nothing changes (stall).
module c1908_resp_misr #(
  parameter int              WIDTH = 25,
  parameter int              CNT_W = 16,
  parameter logic [WIDTH-1:0] POLY = 25'h0000008,
  parameter logic [WIDTH-1:0] SEED = 25'h0000000,
  parameter int              LAT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [WIDTH-1:0] resp_in,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] expected_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SKIP = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int SKIP_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

  logic [1:0]        state;
  logic [SKIP_W-1:0] skip_cnt;
  logic [CNT_W-1:0]  num_lat;
  logic [WIDTH-1:0]  sig_next;
  logic              last_sample;
  logic              last_skip;

  // Next MISR value: shift up, fold the MSB back into bit 0 and the tap bits.
  always_comb begin
    sig_next    = '0;
    sig_next[0] = signature[WIDTH-1] ^ resp_in[0];
    for (int i = 1; i < WIDTH; i++) begin
      sig_next[i] = signature[i-1] ^ resp_in[i] ^ (POLY[i] & signature[WIDTH-1]);
    end
  end

  // Terminal conditions for the sample currently being consumed.
  always_comb begin
    last_sample = ((cycle_count + CNT_W'(1)) == num_lat);
    last_skip   = (skip_cnt == SKIP_W'(LAT - 1));
  end

  // Control FSM together with the signature, counters and verdict.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pass        <= 1'b0;
      signature   <= SEED;
      cycle_count <= '0;
      skip_cnt    <= '0;
      num_lat     <= '0;
    end else if (abort && (state != IDLE)) begin
      // Signature and count are left as-is so an aborted run can be inspected.
      state <= IDLE;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_lat     <= num_cycles;
            signature   <= SEED;
            cycle_count <= '0;
            skip_cnt    <= '0;
            pass        <= 1'b0;
            if (num_cycles == '0) begin
              // Empty run: the seed itself is the final signature.
              state <= DONE;
              pass  <= (SEED == expected_sig);
            end else if (LAT > 0) begin
              state <= SKIP;
            end else begin
              state <= RUN;
            end
          end
        end
        SKIP: begin
          if (resp_valid) begin
            skip_cnt <= skip_cnt + SKIP_W'(1);
            if (last_skip) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (resp_valid) begin
            signature   <= sig_next;
            cycle_count <= cycle_count + CNT_W'(1);
            if (last_sample) begin
              state <= DONE;
              pass  <= (sig_next == expected_sig);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags decode directly from the state register.
  always_comb begin
    busy      = (state == SKIP) || (state == RUN);
    done      = (state == DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_c1908_resp_misr.sv
// tb_c1908_resp_misr: directed plus randomized checks of the response MISR
// against a polynomial-arithmetic reference signature.
module tb_c1908_resp_misr;

  localparam int              W    = 25;
  localparam int              CW   = 16;
  localparam int              LAT  = 2;
  localparam logic [W-1:0]    POLY = 25'h0000008;
  localparam logic [W-1:0]    SEED = 25'h0000000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] num_cycles;
  logic [W-1:0]  resp_in;
  logic          resp_valid;
  logic [W-1:0]  expected_sig;
  logic          busy;
  logic          done;
  logic          pass;
  logic [W-1:0]  signature;
  logic [CW-1:0] cycle_count;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  c1908_resp_misr dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .num_cycles   (num_cycles),
    .resp_in      (resp_in),
    .resp_valid   (resp_valid),
    .expected_sig (expected_sig),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
    .cycle_count  (cycle_count),
    .state_dbg    (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference: signature as polynomial arithmetic mod x^25 + taps + 1.
  function automatic logic [W-1:0] misr_ref(input logic [W-1:0] seed, input logic [W-1:0] q[$]);
    logic [W-1:0] s;
    logic         msb;
    s = seed;
    foreach (q[i]) begin
      msb = s[W-1];
      s   = (s << 1) ^ q[i] ^ (msb ? (POLY | 25'd1) : 25'd0);
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] n);
    start      = 1'b1;
    num_cycles = n;
    resp_valid = 1'b0;
    tick();
    start      = 1'b0;
  endtask

  task automatic feed(input logic v, input logic [W-1:0] d);
    resp_valid = v;
    resp_in    = d;
    tick();
    resp_valid = 1'b0;
  endtask

  // One randomized run: random data, random stalls, random golden value.
  task automatic random_run(input int idx);
    int           n;
    int           sent;
    int           guard;
    logic         want_pass;
    logic [W-1:0] good;
    n = $urandom_range(1, 24);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(W'($urandom));
    good         = misr_ref(SEED, exp_q);
    want_pass    = ($urandom_range(0, 1) == 1);
    expected_sig = want_pass ? good : (good ^ W'($urandom_range(1, 255)));
    do_start(CW'(n));
    for (int i = 0; i < LAT; i++) feed(1'b1, W'($urandom));
    check($sformatf("rnd%0d_busy", idx), 64'(busy), 64'd1);
    sent  = 0;
    guard = 0;
    while (sent < n && guard < 1000) begin
      if ($urandom_range(0, 3) == 0) begin
        feed(1'b0, W'($urandom));
      end else begin
        feed(1'b1, exp_q[sent]);
        sent++;
      end
      guard++;
    end
    check($sformatf("rnd%0d_done", idx), 64'(done), 64'd1);
    check($sformatf("rnd%0d_sig", idx), 64'(signature), 64'(good));
    check($sformatf("rnd%0d_cnt", idx), 64'(cycle_count), 64'(n));
    check($sformatf("rnd%0d_pass", idx), 64'(pass), 64'(want_pass));
  endtask

  initial begin
    logic [W-1:0] held_sig;
    logic [W-1:0] unstalled;
    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    num_cycles   = '0;
    resp_in      = '0;
    resp_valid   = 1'b0;
    expected_sig = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_sig", 64'(signature), 64'(SEED));
    check("rst_cnt", 64'(cycle_count), 64'd0);
    check("rst_busy_done_pass", 64'({busy, done, pass}), 64'd0);

    // Reset in the middle of RUN after three compacted samples.
    do_start(16'd10);
    feed(1'b1, 25'h0AAAAAA);
    feed(1'b1, 25'h1555555);
    for (int i = 0; i < 3; i++) feed(1'b1, W'($urandom));
    check("mid_cnt", 64'(cycle_count), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_state", 64'(state_dbg), 64'd0);
    check("midrst_sig", 64'(signature), 64'd0);
    check("midrst_cnt", 64'(cycle_count), 64'd0);
    check("midrst_busy_done", 64'({busy, done}), 64'd0);

    // Single-sample run: two pipeline-fill samples are discarded.
    expected_sig = 25'h0000001;
    do_start(16'd1);
    feed(1'b1, 25'h0000001);
    feed(1'b1, 25'h0000001);
    check("one_not_done", 64'({busy, done}), 64'b10);
    feed(1'b1, 25'h0000001);
    check("one_sig", 64'(signature), 64'h1);
    check("one_cnt", 64'(cycle_count), 64'd1);
    check("one_done_pass", 64'({done, pass}), 64'b11);

    // Two samples of 1 give 3; golden of 2 must fail.
    expected_sig = 25'h0000002;
    do_start(16'd2);
    for (int i = 0; i < LAT + 2; i++) feed(1'b1, 25'h0000001);
    check("two_sig", 64'(signature), 64'h3);
    check("two_done_pass", 64'({done, pass}), 64'b10);

    // MSB feedback reaches bit 0 and the tap at bit 3.
    expected_sig = 25'h0000009;
    do_start(16'd2);
    feed(1'b1, 25'h0);
    feed(1'b1, 25'h0);
    feed(1'b1, 25'h1000000);
    check("fb_pre", 64'(signature), 64'h1000000);
    feed(1'b1, 25'h0);
    check("fb_sig", 64'(signature), 64'h9);
    check("fb_pass", 64'(pass), 64'd1);

    // Stall mid-run; also a start during RUN must be ignored.
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(W'($urandom));
    unstalled    = misr_ref(SEED, exp_q);
    expected_sig = unstalled;
    do_start(16'd4);
    feed(1'b1, 25'h0);
    feed(1'b1, 25'h0);
    feed(1'b1, exp_q[0]);
    feed(1'b1, exp_q[1]);
    held_sig = signature;
    check("stall_pre_sig", 64'(held_sig), 64'(misr_ref(SEED, exp_q[0:1])));
    for (int i = 0; i < 5; i++) feed(1'b0, W'($urandom));
    check("stall_sig", 64'(signature), 64'(held_sig));
    check("stall_cnt", 64'(cycle_count), 64'd2);
    start      = 1'b1;
    num_cycles = 16'd1;
    feed(1'b1, exp_q[2]);
    start      = 1'b0;
    check("start_in_run_state", 64'(state_dbg), 64'd2);
    check("start_in_run_cnt", 64'(cycle_count), 64'd3);
    feed(1'b1, exp_q[3]);
    check("stall_final_sig", 64'(signature), 64'(unstalled));
    check("stall_final", 64'({done, pass, cycle_count}), {62'b11, 16'd4} );

    // Abort and start together in DONE: abort wins, signature held.
    held_sig = signature;
    abort    = 1'b1;
    do_start(16'd5);
    abort    = 1'b0;
    check("abort_state", 64'(state_dbg), 64'd0);
    check("abort_flags", 64'({busy, done, pass}), 64'd0);
    check("abort_sig_held", 64'(signature), 64'(held_sig));

    // Empty run goes straight to DONE with the seed.
    expected_sig = 25'h1234567;
    do_start(16'd0);
    check("zero_done", 64'({busy, done}), 64'b01);
    check("zero_sig", 64'(signature), 64'(SEED));
    check("zero_cnt", 64'(cycle_count), 64'd0);

    // Abort mid-SKIP returns to IDLE.
    do_start(16'd3);
    feed(1'b1, 25'h0);
    abort = 1'b1;
    feed(1'b1, 25'h0);
    abort = 1'b0;
    check("abort_skip", 64'({state_dbg, busy}), 64'd0);

    for (int r = 0; r < 10; r++) random_run(r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
